seq_mult_n: RTL

- Parametrised sequential shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product.
- Runtime-selectable signed (two's complement) or unsigned mode.
- Start/busy/done handshake, so datapath controllers can issue multiplies without tracking cycle counts.
- Successor to the fixed 8-bit add/subtract-and-shift multiplier. Sits between the register file and the result bus.

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/add_sub_n.sv | 25 ++
 rtl/seq_mult_n.sv | 96 +++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic ADD_OP = 1'b0;
    localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/add_sub_n.sv
// Combinational W-bit adder/subtractor; operands are extended by one bit (sign or zero).
module add_sub_n
    import seq_mult_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic [W-2:0] a,
    input  logic [W-2:0] b,
    input  logic         sub,
    input  logic         sext,
    output logic [W-1:0] sum
);

    logic [W-1:0] a_x;
    logic [W-1:0] b_x;
    logic [W-1:0] b_op;

    always_comb begin
        a_x  = {sext & a[W-2], a};
        b_x  = {sext & b[W-2], b};
        b_op = (sub == SUB_OP) ? ~b_x : b_x;
        sum  = a_x + b_op + W'(sub);
    end

endmodule

// File: rtl/seq_mult_n.sv
// Sequential signed/unsigned shift-add multiplier with start/busy/done handshake.
module seq_mult_n
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic             x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             m_q;
    logic [CNT_W-1:0] cnt_q;

    logic             op_sel;
    logic [WIDTH:0]   sum;

    // The final partial product carries the multiplier's sign weight, so it is subtracted.
    assign op_sel = (m_q && (cnt_q == LastCnt)) ? SUB_OP : ADD_OP;

    add_sub_n #(
        .W(WIDTH + 1)
    ) u_add_sub (
        .a   (a_q),
        .b   (s_q),
        .sub (op_sel),
        .sext(m_q),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        s_q     <= mcand;
                        b_q     <= mplier;
                        m_q     <= signed_mode;
                        a_q     <= '0;
                        x_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    if (b_q[0]) begin
                        {x_q, a_q} <= sum;
                    end
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    x_q     <= m_q ? x_q : 1'b0;
                    a_q     <= {x_q, a_q[WIDTH-1:1]};
                    b_q     <= {a_q[0], b_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= (cnt_q == LastCnt) ? DONE : ADD;
                end
                DONE: begin
                    product <= {a_q, b_q};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
